// File: rtl/and_or_capture_reg_if.sv
// Bundle of the control, data and status signals of and_or_capture_reg.
// The master drives en/mode/clr/din; the slave (the block) returns the captured results.
interface and_or_capture_reg_if #(
    parameter int NUM_CH = 4,
    parameter int TERMS  = 2,
    parameter int TERM_W = 2,
    parameter int CNT_W  = 8
);
    logic                             en;
    logic [1:0]                       mode;
    logic                             clr;
    logic [NUM_CH*TERMS*TERM_W-1:0]   din;
    logic [NUM_CH-1:0]                f;
    logic                             f_valid;
    logic                             chg;
    logic [CNT_W-1:0]                 chg_cnt;

    modport master (
        output en, mode, clr, din,
        input  f, f_valid, chg, chg_cnt
    );

    modport slave (
        input  en, mode, clr, din,
        output f, f_valid, chg, chg_cnt
    );
endinterface

// File: rtl/and_or_capture_reg.sv
// NUM_CH registered sum-of-products channels with four capture modes,
// sticky valid flag, change pulse and saturating change counter.
module and_or_capture_reg #(
    parameter int NUM_CH = 4,
    parameter int TERMS  = 2,
    parameter int TERM_W = 2,
    parameter int CNT_W  = 8
) (
    input logic                clk,
    input logic                rst_n,
    and_or_capture_reg_if.slave bus
);

    typedef enum logic [1:0] {
        FOLLOW     = 2'd0,
        SAMPLE     = 2'd1,
        STICKY     = 2'd2,
        GATED_ZERO = 2'd3
    } mode_t;

    logic [NUM_CH-1:0] g;
    logic [NUM_CH-1:0] f_next;
    logic [NUM_CH-1:0] f_cur;
    logic              valid_cur;
    logic              chg_cur;
    logic [CNT_W-1:0]  cnt_cur;
    logic              en_q;
    logic              rise;
    logic              capture;
    logic              changed;
    mode_t             mode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        g = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int t = 0; t < TERMS; t++) begin
                g[ch] = g[ch] | (&bus.din[(ch*TERMS+t)*TERM_W +: TERM_W]);
            end
        end
    end

    assign mode = mode_t'(bus.mode);
    assign rise = bus.en & ~en_q;

    always_comb begin
        f_next  = f_cur;
        capture = 1'b0;
        case (mode)
            FOLLOW: begin
                if (bus.en) begin
                    f_next  = g;
                    capture = 1'b1;
                end
            end
            SAMPLE: begin
                if (rise) begin
                    f_next  = g;
                    capture = 1'b1;
                end
            end
            STICKY: begin
                if (bus.en) begin
                    f_next  = f_cur | g;
                    capture = 1'b1;
                end
            end
            GATED_ZERO: begin
                // Dropping en forces zero but is not a capture.
                if (bus.en) begin
                    f_next  = g;
                    capture = 1'b1;
                end else begin
                    f_next = '0;
                end
            end
            default: begin
                f_next  = f_cur;
                capture = 1'b0;
            end
        endcase
    end

    assign changed = (f_next != f_cur);

    // en_q tracks en regardless of clr so SAMPLE edge detection survives a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_cur     <= '0;
            valid_cur <= 1'b0;
            chg_cur   <= 1'b0;
            cnt_cur   <= '0;
            en_q      <= 1'b0;
        end else begin
            en_q <= bus.en;
            if (bus.clr) begin
                f_cur     <= '0;
                valid_cur <= 1'b0;
                chg_cur   <= 1'b0;
                cnt_cur   <= '0;
            end else begin
                f_cur     <= f_next;
                valid_cur <= valid_cur | capture;
                chg_cur   <= changed;
                if (changed) begin
                    cnt_cur <= sat_inc(cnt_cur);
                end
            end
        end
    end

    assign bus.f       = f_cur;
    assign bus.f_valid = valid_cur;
    assign bus.chg     = chg_cur;
    assign bus.chg_cnt = cnt_cur;

endmodule

// File: tb/tb_and_or_capture_reg.sv
// Scoreboard bench: two instances (8-bit and 2-bit change counters) share stimulus;
// a spec-level model queues expected results and a monitor compares after each edge.
module tb_and_or_capture_reg;

    localparam int NUM_CH = 4;
    localparam int TERMS  = 2;
    localparam int TERM_W = 2;
    localparam int DIN_W  = NUM_CH*TERMS*TERM_W;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    and_or_capture_reg_if #(.NUM_CH(NUM_CH), .TERMS(TERMS), .TERM_W(TERM_W), .CNT_W(8)) bus8 ();
    and_or_capture_reg_if #(.NUM_CH(NUM_CH), .TERMS(TERMS), .TERM_W(TERM_W), .CNT_W(2)) bus2 ();

    and_or_capture_reg #(.NUM_CH(NUM_CH), .TERMS(TERMS), .TERM_W(TERM_W), .CNT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    and_or_capture_reg #(.NUM_CH(NUM_CH), .TERMS(TERMS), .TERM_W(TERM_W), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    typedef struct {
        int f;
        bit valid;
        bit chg;
        int cnt;
        int want_f;
        int idx;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    // Reference model state (spec level: unbounded change count, clipped per width on compare)
    int m_f       = 0;
    bit m_valid   = 0;
    bit m_chg     = 0;
    int m_cnt     = 0;
    bit m_en_prev = 0;

    function automatic int model_g(input logic [DIN_W-1:0] d);
        int res = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int t = 0; t < TERMS; t++) begin
                int off  = (ch*TERMS + t)*TERM_W;
                int mask = (1 << TERM_W) - 1;
                if (((int'(d) >> off) & mask) == mask) res = res | (1 << ch);
            end
        end
        return res;
    endfunction

    function automatic int clip(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    task automatic step(input bit r, input bit e, input int m, input bit c,
                        input logic [DIN_W-1:0] d, input int want);
        exp_t x;
        int   gv;
        int   nf;
        bit   cap;
        @(negedge clk);
        rst_n     = r;
        bus8.en   = e;  bus2.en   = e;
        bus8.mode = 2'(m); bus2.mode = 2'(m);
        bus8.clr  = c;  bus2.clr  = c;
        bus8.din  = d;  bus2.din  = d;

        if (!r) begin
            m_f = 0; m_valid = 0; m_chg = 0; m_cnt = 0; m_en_prev = 0;
        end else begin
            gv  = model_g(d);
            nf  = m_f;
            cap = 0;
            case (m)
                0: if (e) begin nf = gv; cap = 1; end
                1: if (e && !m_en_prev) begin nf = gv; cap = 1; end
                2: if (e) begin nf = m_f | gv; cap = 1; end
                default: if (e) begin nf = gv; cap = 1; end else nf = 0;
            endcase
            m_en_prev = e;
            if (c) begin
                m_f = 0; m_valid = 0; m_chg = 0; m_cnt = 0;
            end else begin
                m_chg = (nf != m_f);
                if (m_chg) m_cnt++;
                m_f = nf;
                m_valid = m_valid | cap;
            end
        end
        x.f = m_f; x.valid = m_valid; x.chg = m_chg; x.cnt = m_cnt;
        x.want_f = want; x.idx = step_no;
        step_no++;
        q.push_back(x);
    endtask

    // Monitor: every edge yields one output sample per queued stimulus.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("f",        x.idx, int'(bus8.f),       x.f);
                check("f_valid",  x.idx, int'(bus8.f_valid), int'(x.valid));
                check("chg",      x.idx, int'(bus8.chg),     int'(x.chg));
                check("chg_cnt8", x.idx, int'(bus8.chg_cnt), clip(x.cnt, 8));
                check("f_w2",     x.idx, int'(bus2.f),       x.f);
                check("chg_cnt2", x.idx, int'(bus2.chg_cnt), clip(x.cnt, 2));
                if (x.want_f >= 0) check("f_directed", x.idx, int'(bus8.f), x.want_f);
            end
        end
    end

    initial begin
        int want;
        int mode_r;
        logic [DIN_W-1:0] d;
        mode_r = 0;

        // Reset with everything asserted, then release
        step(0, 1, 0, 0, 16'hFFFF, 0);
        step(0, 1, 0, 0, 16'hFFFF, 0);
        step(1, 1, 0, 0, 16'hFFFF, 15);

        // FOLLOW sweep on channel 0, then hold with en low
        for (int v = 0; v < 16; v++) begin
            want = (((v & 1) != 0 && (v & 2) != 0) || ((v & 4) != 0 && (v & 8) != 0)) ? 1 : 0;
            step(1, 1, 0, 0, 16'(v), want);
        end
        for (int v = 0; v < 16; v++) step(1, 0, 0, 0, 16'(v), 1);
        step(1, 1, 0, 0, 16'h0003, 1);
        step(1, 1, 0, 0, 16'h0005, 0);
        step(1, 1, 0, 0, 16'h000C, 1);

        // SAMPLE
        step(1, 0, 1, 0, 16'h0000, 1);
        step(1, 1, 1, 0, 16'hFFFF, 15);
        step(1, 1, 1, 0, 16'h0000, 15);
        step(1, 0, 1, 0, 16'h0000, 15);
        step(1, 1, 1, 0, 16'h0000, 0);
        step(1, 1, 0, 0, 16'hFFFF, 15);
        step(1, 1, 1, 0, 16'h0000, 15);

        // STICKY with clear
        step(1, 1, 2, 1, 16'h0000, 0);
        step(1, 1, 2, 0, 16'h0003, 1);
        step(1, 1, 2, 0, 16'h0030, 3);
        step(1, 1, 2, 0, 16'h0000, 3);
        step(1, 1, 2, 1, 16'hFFFF, 0);

        // GATED_ZERO
        step(1, 1, 3, 0, 16'hFFFF, 15);
        step(1, 0, 3, 0, 16'hFFFF, 0);

        // Counter saturation on the 2-bit instance
        step(1, 1, 0, 1, 16'h0000, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, (i % 2 == 0) ? 16'h0003 : 16'h0000, (i % 2 == 0) ? 1 : 0);

        // Mid-operation reset
        step(0, 1, 2, 0, 16'hFFFF, 0);
        step(1, 1, 2, 0, 16'h0300, 4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) mode_r = int'($urandom_range(0, 3));
            d = DIN_W'($urandom() | $urandom());
            step(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                 mode_r,
                 ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                 d, -1);
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/and_or_capture_reg.md
Name: and_or_capture_reg

Overview:
Parametrised, clocked successor to the single AND-OR latch. It evaluates NUM_CH independent sum-of-products functions. Each function is an OR of TERMS product terms, and each product term is an AND of TERM_W inputs. Results are captured into flip-flops under one of four enable modes. The block also reports valid, change-pulse and change-count status, and serves as the gated logic-function primitive for the fundamental-hardware test blocks.

Parameters:
NUM_CH, 4, number of independent output channels
TERMS, 2, product terms per channel (>=1)
TERM_W, 2, inputs per product term (>=1)
CNT_W, 8, width of saturating change counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  capture enable (meaning set by mode)
mode  input  2  0=FOLLOW, 1=SAMPLE, 2=STICKY, 3=GATED_ZERO
clr  input  1  synchronous clear of f, f_valid, chg, chg_cnt
din  input  NUM_CH*TERMS*TERM_W  product-term inputs
f  output  NUM_CH  registered channel results
f_valid  output  1  high once any capture has occurred since reset/clr
chg  output  1  one-cycle pulse: f changed on this edge
chg_cnt  output  CNT_W  saturating count of edges on which f changed

Behaviour:
- Combinational evaluation, per channel ch and term t:
  - Term slice = din[(ch*TERMS+t)*TERM_W +: TERM_W].
  - p[ch][t] = AND-reduce of the slice.
  - g[ch] = OR-reduce over t of p[ch][t].
- Internal en_q register: en_q <= en every cycle, independent of mode. Reset value 0. clr does not affect en_q.
- rise = en & ~en_q.
- Priority at each rising clk edge: rst_n=0, then clr=1, then mode action.
- Reset (rst_n=0): f=0, f_valid=0, chg=0, chg_cnt=0, en_q=0. Reset applied mid-operation takes effect on the same edge and discards all state.
- clr=1 (rst_n=1): f=0, f_valid=0, chg=0, chg_cnt=0. clr overrides a simultaneous en/rise.
- Mode actions, producing f_next:
  - FOLLOW: en=1 -> f_next=g; en=0 -> hold.
  - SAMPLE: rise=1 -> f_next=g; otherwise hold. Capture happens once per en assertion.
  - STICKY: en=1 -> f_next=f|g; en=0 -> hold. Bits only clear via clr or reset.
  - GATED_ZERO: en=1 -> f_next=g; en=0 -> f_next=0.
- Capture event:
  - FOLLOW/STICKY/GATED_ZERO: en=1.
  - SAMPLE: rise=1.
  - A capture event sets f_valid=1, which is sticky until clr or reset.
  - GATED_ZERO with en=0 is not a capture event.
- Latency: f reflects din sampled one edge earlier. There is no combinational path from din to f.
- chg <= (f_next != f), registered, so chg is high in the same cycle f shows its new value. Forced to 0 on clr/reset.
- chg_cnt increments on each edge with f_next != f. It saturates at 2^CNT_W-1 and does not wrap.
- Mode changes take effect on the next edge. Switching into SAMPLE while en is already high does not capture, because en_q is already 1.
- When mode changes, f keeps its value; no implicit clear.
- Outputs are held whenever no capture event occurs, except GATED_ZERO with en=0.

Test Plan:
1. Reset (defaults: 16-bit din): rst_n=0 for 2 cycles with din=16'hFFFF, en=1, mode=0 -> f=4'h0, f_valid=0, chg=0, chg_cnt=0. Release -> next cycle f=4'hF, f_valid=1, chg=1, chg_cnt=1.
2. FOLLOW, exhaustive on channel 0:
   - en=1, sweep din[3:0] over 0..15 (other bits 0) -> f[0] one cycle later = (d0&d1)|(d2&d3). Check 4'b0011->1, 4'b0101->0, 4'b1100->1.
   - Then en=0 with the last value 15 and sweep again -> f[0] holds 1 throughout.
3. SAMPLE, mode=1:
   - en rises with din=16'hFFFF -> f=4'hF after one edge.
   - din=0 while en stays high -> f stays 4'hF.
   - en low one cycle, then high with din=0 -> f=4'h0.
   - Switch into SAMPLE with en already high -> no capture.
4. STICKY plus clr, mode=2, en=1:
   - din=16'h0003 -> f=4'b0001.
   - din=16'h0030 -> f=4'b0011.
   - din=0 -> f stays 4'b0011.
   - clr=1 with en=1 -> f=0, f_valid=0, chg=0, chg_cnt=0 (clr wins).
5. GATED_ZERO, mode=3:
   - en=1 with din=16'hFFFF -> f=4'hF.
   - en=0 -> f=4'h0 next cycle, chg=1, f_valid stays 1.
6. Counter saturation, CNT_W=2, mode=0, en=1: toggle din[1:0] between 2'b11 and 2'b00 for 5 changes -> chg pulses 5 times, chg_cnt = 1,2,3,3,3.
